alu_div: RTL



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_div_if.sv | 28 ++
 rtl/alu_div_step.sv | 23 ++
 rtl/alu_div.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage divider: state encoding and constants.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = '1;

endpackage

// File: rtl/alu_div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
interface alu_div_if #(
  parameter int WIDTH = alu_pkg::DIV_WIDTH
) ();

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             zero;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start_i, signed_i, src1, src2,
    input  busy_o, done_o, quotient, remainder, zero, div_by_zero, overflow
  );

  modport slave (
    input  start_i, signed_i, src1, src2,
    output busy_o, done_o, quotient, remainder, zero, div_by_zero, overflow
  );

endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit of trial acts as the borrow: set means the subtraction went negative.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_next = {dvd[WIDTH-2:0], q_bit};

endmodule

// File: rtl/alu_div.sv
// Multi-cycle restoring divider, one quotient bit per clock, with sign fix-up and status flags.
module alu_div
  import alu_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_div_if.slave bus
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem, dvd, divisor, src1_raw;
  logic             neg_q, neg_r, dz, ovf;
  logic [WIDTH-1:0] rem_next, dvd_next;
  logic             q_bit;
  logic [WIDTH-1:0] mag1, mag2, q_fixed, r_fixed;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             zero_q, dz_q, ovf_q;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (divisor),
    .rem_next (rem_next),
    .dvd_next (dvd_next),
    .q_bit    (q_bit)
  );

  assign accept = (state == IDLE) && bus.start_i;
  // The magnitude of the most-negative value still fits in WIDTH unsigned bits.
  assign mag1    = (bus.signed_i && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
  assign mag2    = (bus.signed_i && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  assign q_fixed = neg_q ? -dvd : dvd;
  assign r_fixed = neg_r ? -rem : rem;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start_i) state_next = (bus.src2 == '0) ? FIX : RUN;
      RUN:  if (counter == CNT_W'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state == RUN) || (state == FIX);
    bus.done_o = (state == DONE);
  end

  // NOTE: the datapath is reset too, so an aborted division leaves no stale operands behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      counter  <= '0;
      rem      <= '0;
      dvd      <= '0;
      divisor  <= '0;
      src1_raw <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      counter  <= CNT_W'(WIDTH);
      rem      <= '0;
      dvd      <= mag1;
      divisor  <= mag2;
      src1_raw <= bus.src1;
      neg_q    <= bus.signed_i && (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
      neg_r    <= bus.signed_i && bus.src1[WIDTH-1];
      dz       <= (bus.src2 == '0);
      ovf      <= bus.signed_i && (bus.src1 == MOST_NEG) && (bus.src2 == '1);
    end else if (state == RUN) begin
      counter <= counter - CNT_W'(1);
      rem     <= rem_next;
      dvd     <= dvd_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (state == FIX) begin
      if (dz) begin
        quotient_q  <= {WIDTH{DIV_DZ_QUOTIENT[0]}};
        remainder_q <= src1_raw;
        zero_q      <= 1'b0;
        dz_q        <= 1'b1;
        ovf_q       <= 1'b0;
      end else begin
        quotient_q  <= q_fixed;
        remainder_q <= r_fixed;
        zero_q      <= (dvd == '0);
        dz_q        <= 1'b0;
        ovf_q       <= ovf;
      end
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;

endmodule
